// File: rtl/memoredf_pkg.sv
// Shared MemorEDF definitions: packet geometry, metadata struct, FSM states
// and the helper that lays a captured transaction out as a packet.
package memoredf_pkg;

  localparam int PACKET_W  = 678;
  localparam int META_W    = 101;
  localparam int MAX_BEATS = 4;
  localparam int DATA_W    = 128;
  localparam int STRB_W    = 16;

  // Bit positions inside the packet
  localparam int TYPE_BIT  = 677;   // 1 = write, 0 = read
  localparam int STRB_MSB  = 575;   // strobe of beat i at [STRB_MSB-16i -: 16]
  localparam int DATA_MSB  = 511;   // data of beat i at [DATA_MSB-128i -: 128]

  // Metadata block, MSB first; the Serializer decodes the same struct
  typedef struct packed {
    logic [39:0] addr;
    logic [15:0] id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [15:0] user;
  } meta_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_PUSH  = 2'd2,
    ST_BRESP = 2'd3
  } state_t;

  // Slot 0 sits at the top of the strobe and data regions
  function automatic logic [PACKET_W-1:0] pack_packet(
    input logic                               typ,
    input meta_t                              m,
    input logic [MAX_BEATS-1:0][STRB_W-1:0]   s,
    input logic [MAX_BEATS-1:0][DATA_W-1:0]   d
  );
    logic [PACKET_W-1:0] p;
    p = '0;
    p[TYPE_BIT] = typ;
    p[TYPE_BIT-1 -: META_W] = m;
    for (int i = 0; i < MAX_BEATS; i++) begin
      p[STRB_MSB-STRB_W*i -: STRB_W] = s[i];
      p[DATA_MSB-DATA_W*i -: DATA_W] = d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/packet_arbiter_rr.sv
// Two-requester round-robin (write vs read) with a last-grant register.
// Comes out of reset pointing at read so that write wins the first tie.
module packet_arbiter_rr (
  input  logic clk,
  input  logic rst,
  input  logic req_w,
  input  logic req_r,
  input  logic upd,
  output logic gnt_w,
  output logic gnt_r
);

  logic last_r;

  assign gnt_w = req_w & (~req_r | last_r);
  assign gnt_r = req_r & ~gnt_w;

  // Remember which channel took the last accepted grant
  always_ff @(posedge clk) begin
    if (rst)      last_r <= 1'b1;
    else if (upd) last_r <= gnt_r;
  end

endmodule

// File: rtl/axi_packetizer.sv
// AXI4 slave front end: each AR or AW+W burst becomes one 678-bit packet
// on a valid/ready port; writes are posted with an OKAY B response after
// the packet handoff. One transaction in flight at a time.
module axi_packetizer
  import memoredf_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 16,
  parameter int C_S_AXI_ADDR_WIDTH = 40,
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int C_S_AXI_USER_WIDTH = 16,
  parameter int C_MAX_BEATS        = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWLOCK,
  input  logic [3:0]                      S_AXI_AWCACHE,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic [3:0]                      S_AXI_AWQOS,
  input  logic [3:0]                      S_AXI_AWREGION,
  input  logic [C_S_AXI_USER_WIDTH-1:0]   S_AXI_AWUSER,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARLOCK,
  input  logic [3:0]                      S_AXI_ARCACHE,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic [3:0]                      S_AXI_ARQOS,
  input  logic [3:0]                      S_AXI_ARREGION,
  input  logic [C_S_AXI_USER_WIDTH-1:0]   S_AXI_ARUSER,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic                            valid,
  input  logic                            ready,
  output logic [PACKET_W-1:0]             packet,
  output logic                            len_error
);

  state_t                             state;
  meta_t                              meta_q;
  logic                               type_q;
  logic [MAX_BEATS-1:0][STRB_W-1:0]   strb_q;
  logic [MAX_BEATS-1:0][DATA_W-1:0]   data_q;
  logic [2:0]                         beat_cnt;   // saturating slot pointer
  logic [7:0]                         beat_idx;   // beat index for the WLAST/AWLEN check
  logic                               valid_q, bvalid_q;
  logic [C_S_AXI_ID_WIDTH-1:0]        bid_q;
  logic                               gnt_w, gnt_r, idle, aw_hs, ar_hs;
  meta_t                              aw_meta, ar_meta;

  assign aw_meta = {S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                    S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                    S_AXI_AWREGION, S_AXI_AWUSER};
  assign ar_meta = {S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
                    S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                    S_AXI_ARREGION, S_AXI_ARUSER};

  // Ready lines are combinational but held low while reset is asserted
  assign idle          = (state == ST_IDLE) && !S_AXI_ARESET;
  assign S_AXI_AWREADY = idle & gnt_w;
  assign S_AXI_ARREADY = idle & gnt_r;
  assign S_AXI_WREADY  = (state == ST_WDATA) && !S_AXI_ARESET;
  assign aw_hs         = S_AXI_AWVALID & S_AXI_AWREADY;
  assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign valid         = valid_q;
  assign packet        = pack_packet(type_q, meta_q, strb_q, data_q);

  packet_arbiter_rr u_arb (
    .clk   (S_AXI_ACLK),
    .rst   (S_AXI_ARESET),
    .req_w (S_AXI_AWVALID),
    .req_r (S_AXI_ARVALID),
    .upd   (aw_hs | ar_hs),
    .gnt_w (gnt_w),
    .gnt_r (gnt_r)
  );

  // Transaction FSM: capture address, collect beats, hand off, respond
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state     <= ST_IDLE;
      meta_q    <= '0;
      type_q    <= 1'b0;
      strb_q    <= '0;
      data_q    <= '0;
      beat_cnt  <= '0;
      beat_idx  <= '0;
      valid_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      len_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            meta_q   <= aw_meta;
            type_q   <= 1'b1;
            strb_q   <= '0;
            data_q   <= '0;
            beat_cnt <= '0;
            beat_idx <= '0;
            state    <= ST_WDATA;
          end else if (ar_hs) begin
            meta_q   <= ar_meta;
            type_q   <= 1'b0;
            strb_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b1;
            state    <= ST_PUSH;
          end
        end
        ST_WDATA: begin
          if (S_AXI_WVALID) begin
            // Beats past the last slot are accepted but dropped
            if (beat_cnt < 3'(C_MAX_BEATS)) begin
              strb_q[beat_cnt[1:0]] <= S_AXI_WSTRB;
              data_q[beat_cnt[1:0]] <= S_AXI_WDATA;
              beat_cnt              <= beat_cnt + 3'd1;
            end else begin
              len_error <= 1'b1;
            end
            beat_idx <= beat_idx + 8'd1;
            if (S_AXI_WLAST) begin
              if (beat_idx != meta_q.len) len_error <= 1'b1;
              valid_q <= 1'b1;
              state   <= ST_PUSH;
            end
          end
        end
        ST_PUSH: begin
          if (ready) begin
            valid_q <= 1'b0;
            if (type_q) begin
              bvalid_q <= 1'b1;
              bid_q    <= meta_q.id;
              state    <= ST_BRESP;
            end else begin
              state    <= ST_IDLE;
            end
          end
        end
        ST_BRESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
